// File: rtl/sci_alu_issue_queue.sv
// -----------------------------------------------------------------------------
// sci_alu_issue_queue
//
// Command stage in front of the scientific ALU. Requests {a, b, opcode} are
// buffered in a DEPTH-entry FIFO and issued one at a time. The issued operands
// are held on alu_a/alu_b/alu_opcode until the result is captured, and the
// captured result is offered on a valid/ready output port. Only one operation
// is in flight at any time.
//
// Ports:
//   clock, reset_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready       request handshake; in_ready = (count != DEPTH)
//   in_a, in_b, in_opcode   request payload (IEEE-754 bit vectors, opcode)
//   alu_a, alu_b,
//   alu_opcode              registered operands/opcode to the ALU
//   alu_start               one-cycle issue strobe
//   alu_result, alu_excep,
//   alu_err                 ALU outputs, sampled once per operation
//   out_valid/out_ready     result handshake
//   out_result, out_excep,
//   out_err, out_opcode     captured result and the opcode that produced it
//   count                   FIFO occupancy, not counting the in-flight op
// -----------------------------------------------------------------------------
module sci_alu_issue_queue #(
    parameter int DEPTH       = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [63:0]            in_a,
    input  logic [63:0]            in_b,
    input  logic [3:0]             in_opcode,
    output logic [63:0]            alu_a,
    output logic [63:0]            alu_b,
    output logic [3:0]             alu_opcode,
    output logic                   alu_start,
    input  logic [63:0]            alu_result,
    input  logic                   alu_excep,
    input  logic                   alu_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_result,
    output logic                   out_excep,
    output logic                   out_err,
    output logic [3:0]             out_opcode,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(ALU_LATENCY) + 1;

    localparam logic [LW-1:0] LAT_INIT = LW'(ALU_LATENCY - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // FIFO storage: contents need no reset, pointers/count define validity.
    logic [63:0] mem_a  [DEPTH];
    logic [63:0] mem_b  [DEPTH];
    logic [3:0]  mem_op [DEPTH];

    logic [1:0]    state_q,      state_d;
    logic [AW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,     rd_ptr_d;
    logic [CW-1:0] count_q,      count_d;
    logic [LW-1:0] lat_q,        lat_d;
    logic [63:0]   alu_a_q,      alu_a_d;
    logic [63:0]   alu_b_q,      alu_b_d;
    logic [3:0]    alu_op_q,     alu_op_d;
    logic          start_q,      start_d;
    logic          out_valid_q,  out_valid_d;
    logic [63:0]   out_result_q, out_result_d;
    logic          out_excep_q,  out_excep_d;
    logic          out_err_q,    out_err_d;
    logic [3:0]    out_op_q,     out_op_d;

    logic push;
    logic issue;

    assign in_ready = (count_q != FULL_CNT);
    assign push     = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        lat_d        = lat_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        start_d      = 1'b0;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_excep_d  = out_excep_q;
        out_err_d    = out_err_q;
        out_op_d     = out_op_q;
        issue        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    issue = 1'b1;
                end
            end
            S_WAIT: begin
                // The strobe cycle itself is not counted: the ALU sees
                // alu_start at the edge after issue, and its result is valid
                // ALU_LATENCY clocks after that.
                if (!start_q) begin
                    if (lat_q == '0) begin
                        out_valid_d  = 1'b1;
                        out_result_d = alu_result;
                        out_excep_d  = alu_excep;
                        out_err_d    = alu_err;
                        out_op_d     = alu_op_q;
                        state_d      = S_HOLD;
                    end else begin
                        lat_d = lat_q - LW'(1);
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    if (count_q != '0) begin
                        issue = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            alu_a_d  = mem_a[rd_ptr_q];
            alu_b_d  = mem_b[rd_ptr_q];
            alu_op_d = mem_op[rd_ptr_q];
            start_d  = 1'b1;
            lat_d    = LAT_INIT;
            rd_ptr_d = rd_ptr_q + AW'(1);
            state_d  = S_WAIT;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        // Push is blocked while full and issue requires a non-empty FIFO,
        // so count never over/underflows.
        case ({push, issue})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_a[wr_ptr_q]  <= in_a;
            mem_b[wr_ptr_q]  <= in_b;
            mem_op[wr_ptr_q] <= in_opcode;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lat_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            start_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_excep_q  <= 1'b0;
            out_err_q    <= 1'b0;
            out_op_q     <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lat_q        <= lat_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            start_q      <= start_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_excep_q  <= out_excep_d;
            out_err_q    <= out_err_d;
            out_op_q     <= out_op_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign alu_start  = start_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_excep  = out_excep_q;
    assign out_err    = out_err_q;
    assign out_opcode = out_op_q;
    assign count      = count_q;

endmodule

// File: tb/tb_sci_alu_issue_queue.sv
// -----------------------------------------------------------------------------
// Testbench for sci_alu_issue_queue: one instance with ALU_LATENCY=1 and one
// with ALU_LATENCY=3, each driven by a small behavioural ALU stub.
// -----------------------------------------------------------------------------
module tb_sci_alu_issue_queue;

    localparam logic [63:0] F16 = 64'h4030000000000000;
    localparam logic [63:0] F2  = 64'h4000000000000000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- instance with ALU_LATENCY = 1 ----------------
    logic        reset_n1, in_valid1, in_ready1, alu_start1, alu_excep1, alu_err1;
    logic        out_valid1, out_ready1, out_excep1, out_err1;
    logic [63:0] in_a1, in_b1, alu_a1, alu_b1, alu_result1, out_result1;
    logic [3:0]  in_opcode1, alu_opcode1, out_opcode1;
    logic [2:0]  count1;
    logic        err_glitch, exc_glitch;

    // ---------------- instance with ALU_LATENCY = 3 ----------------
    logic        reset_n3, in_valid3, in_ready3, alu_start3, alu_excep3, alu_err3;
    logic        out_valid3, out_ready3, out_excep3, out_err3;
    logic [63:0] in_a3, in_b3, alu_a3, alu_b3, alu_result3, out_result3;
    logic [3:0]  in_opcode3, alu_opcode3, out_opcode3;
    logic [2:0]  count3;

    // ALU stub behaviour
    function automatic logic [63:0] stub_res(input logic [63:0] a, input logic [63:0] b,
                                             input logic [3:0] op);
        case (op)
            4'd0:    return $realtobits($bitstoreal(a) + $bitstoreal(b));
            4'd1:    return $realtobits($bitstoreal(a) - $bitstoreal(b));
            4'd2:    return $realtobits($bitstoreal(a) * $bitstoreal(b));
            4'd3:    return $realtobits($bitstoreal(a) / $bitstoreal(b));
            default: return a ^ {60'd0, op};
        endcase
    endfunction

    function automatic logic stub_exc(input logic [3:0] op);
        return (op == 4'd5) || (op == 4'd12);
    endfunction

    function automatic logic stub_err(input logic [3:0] op);
        return (op == 4'd5) || (op == 4'd15);
    endfunction

    // Hand-computed expected results for a=16.0, b=2.0
    function automatic logic [63:0] exp_res(input logic [3:0] op);
        case (op)
            4'd0:    return 64'h4032000000000000; // 18.0
            4'd1:    return 64'h402C000000000000; // 14.0
            4'd2:    return 64'h4040000000000000; // 32.0
            4'd3:    return 64'h4020000000000000; //  8.0
            default: return 64'h4030000000000000 | {60'd0, op};
        endcase
    endfunction

    localparam logic [15:0] EXC_MASK = 16'h1020; // opcodes 5, 12
    localparam logic [15:0] ERR_MASK = 16'h8020; // opcodes 5, 15

    assign alu_result1 = stub_res(alu_a1, alu_b1, alu_opcode1);
    assign alu_excep1  = stub_exc(alu_opcode1) | exc_glitch;
    assign alu_err1    = stub_err(alu_opcode1) | err_glitch;

    assign alu_result3 = stub_res(alu_a3, alu_b3, alu_opcode3);
    assign alu_excep3  = stub_exc(alu_opcode3);
    assign alu_err3    = stub_err(alu_opcode3);

    sci_alu_issue_queue #(.DEPTH(4), .ALU_LATENCY(1)) dut1 (
        .clock(clock), .reset_n(reset_n1),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_opcode(in_opcode1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_opcode(alu_opcode1), .alu_start(alu_start1),
        .alu_result(alu_result1), .alu_excep(alu_excep1), .alu_err(alu_err1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_result(out_result1), .out_excep(out_excep1), .out_err(out_err1),
        .out_opcode(out_opcode1), .count(count1)
    );

    sci_alu_issue_queue #(.DEPTH(4), .ALU_LATENCY(3)) dut3 (
        .clock(clock), .reset_n(reset_n3),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .in_a(in_a3), .in_b(in_b3), .in_opcode(in_opcode3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_opcode(alu_opcode3), .alu_start(alu_start3),
        .alu_result(alu_result3), .alu_excep(alu_excep3), .alu_err(alu_err3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_result(out_result3), .out_excep(out_excep3), .out_err(out_err3),
        .out_opcode(out_opcode3), .count(count3)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    int   pushed, got, cyc, next_op;
    logic will_push, saw_full, bad;

    initial begin
        reset_n1 = 1'b0; in_valid1 = 1'b0; in_a1 = F16; in_b1 = F2; in_opcode1 = 4'd0;
        out_ready1 = 1'b1; err_glitch = 1'b0; exc_glitch = 1'b0;
        reset_n3 = 1'b0; in_valid3 = 1'b0; in_a3 = F16; in_b3 = F2; in_opcode3 = 4'd0;
        out_ready3 = 1'b1;
        step(); step();
        reset_n1 = 1'b1; reset_n3 = 1'b1;

        // Reset state
        chk("rst_count",    count1,      3'd0);
        chk("rst_in_ready", in_ready1,   1'b1);
        chk("rst_start",    alu_start1,  1'b0);
        chk("rst_out_vld",  out_valid1,  1'b0);
        chk("rst_alu_a",    alu_a1,      64'd0);
        chk("rst_out_res",  out_result1, 64'd0);
        chk("rst_out_op",   out_opcode1, 4'd0);
        chk("rst3_count",   count3,      3'd0);

        // 1. Single op
        in_valid1 = 1'b1; in_opcode1 = 4'd0;
        step();
        in_valid1 = 1'b0;
        chk("t1_count_push", count1, 3'd1);
        chk("t1_no_start",   alu_start1, 1'b0);
        step();
        chk("t1_start",  alu_start1, 1'b1);
        chk("t1_alu_a",  alu_a1, F16);
        chk("t1_alu_b",  alu_b1, F2);
        chk("t1_count0", count1, 3'd0);
        step();
        chk("t1_start_1cyc", alu_start1, 1'b0);
        chk("t1_not_yet",    out_valid1, 1'b0);
        step();
        chk("t1_out_vld", out_valid1,  1'b1);
        chk("t1_out_res", out_result1, 64'h4032000000000000);
        chk("t1_out_op",  out_opcode1, 4'd0);
        step();
        chk("t1_accepted", out_valid1, 1'b0);

        // 2. Sweep opcodes 0..15
        pushed = 0; got = 0; cyc = 0; saw_full = 1'b0;
        while (got < 16 && cyc < 400) begin
            in_valid1  = (pushed < 16);
            in_opcode1 = pushed[3:0];
            will_push  = in_valid1 && in_ready1;
            step();
            if (will_push) pushed++;
            if (out_valid1) begin
                chk("t2_op",  out_opcode1, got[3:0]);
                chk("t2_res", out_result1, exp_res(got[3:0]));
                chk("t2_exc", out_excep1,  EXC_MASK[got[3:0]]);
                chk("t2_err", out_err1,    ERR_MASK[got[3:0]]);
                got++;
            end
            if (count1 == 3'd4 && !saw_full) begin
                chk("t2_full_ready", in_ready1, 1'b0);
                saw_full = 1'b1;
            end
            cyc++;
        end
        in_valid1 = 1'b0;
        chk("t2_all_results", got, 16);
        chk("t2_saw_full", saw_full, 1'b1);
        step();

        // 3. Backpressure
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_opcode1 = 4'd2; step();
        in_opcode1 = 4'd3; step();
        chk("t3_start", alu_start1, 1'b1);
        in_opcode1 = 4'd4; step();
        in_opcode1 = 4'd5; step();
        chk("t3_first_vld", out_valid1, 1'b1);
        in_opcode1 = 4'd6; step();
        chk("t3_full", count1, 3'd4);
        in_opcode1 = 4'd7;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_stable", out_valid1 && out_result1 == exp_res(4'd2) &&
                out_opcode1 == 4'd2 && !alu_start1 && count1 == 3'd4 && !in_ready1, 1'b1);
        end

        // 4. Accept with issue while full, push presented on same edge
        out_ready1 = 1'b1;
        step();
        chk("t4_accept_vld", out_valid1,  1'b0);
        chk("t4_issue",      alu_start1,  1'b1);
        chk("t4_issue_op",   alu_opcode1, 4'd3);
        chk("t4_count3",     count1,      3'd3);
        chk("t4_ready_up",   in_ready1,   1'b1);
        step();
        in_valid1 = 1'b0;
        chk("t4_pushed_next", count1, 3'd4);
        next_op = 3; cyc = 0;
        while (next_op < 8 && cyc < 100) begin
            step();
            if (out_valid1) begin
                chk("t4_drain_op",  out_opcode1, next_op[3:0]);
                chk("t4_drain_res", out_result1, exp_res(next_op[3:0]));
                next_op++;
            end
            cyc++;
        end
        chk("t4_drain_done", next_op, 8);
        step();

        // 6. Error propagation and glitch rejection
        in_valid1 = 1'b1; in_opcode1 = 4'd0; step();
        in_valid1 = 1'b0; step();
        chk("t6a_start", alu_start1, 1'b1);
        err_glitch = 1'b1; exc_glitch = 1'b1; step();
        err_glitch = 1'b0; exc_glitch = 1'b0; step();
        chk("t6a_vld", out_valid1, 1'b1);
        chk("t6a_err", out_err1,   1'b0);
        chk("t6a_exc", out_excep1, 1'b0);
        step();
        in_valid1 = 1'b1; in_opcode1 = 4'd5; step();
        in_valid1 = 1'b0; step();
        err_glitch = 1'b1; step();
        err_glitch = 1'b0; step();
        chk("t6b_vld", out_valid1,  1'b1);
        chk("t6b_err", out_err1,    1'b1);
        chk("t6b_exc", out_excep1,  1'b1);
        chk("t6b_op",  out_opcode1, 4'd5);
        chk("t6b_res", out_result1, 64'h4030000000000005);
        step();
        chk("t6b_accept", out_valid1, 1'b0);

        // 5. ALU_LATENCY = 3: normal op, then reset mid-WAIT
        in_valid3 = 1'b1; in_opcode3 = 4'd0; step();
        in_valid3 = 1'b0; step();
        chk("t5_start", alu_start3, 1'b1);
        step(); step(); step();
        chk("t5_not_yet", out_valid3, 1'b0);
        step();
        chk("t5_vld", out_valid3,  1'b1);
        chk("t5_res", out_result3, 64'h4032000000000000);
        step();
        in_valid3 = 1'b1; in_opcode3 = 4'd1; step();
        in_opcode3 = 4'd2; step();
        in_valid3 = 1'b0;
        chk("t5_issue2", alu_start3, 1'b1);
        step(); step();
        reset_n3 = 1'b0; step();
        reset_n3 = 1'b1;
        chk("t5_rst_count", count3,     3'd0);
        chk("t5_rst_ready", in_ready3,  1'b1);
        chk("t5_rst_start", alu_start3, 1'b0);
        chk("t5_rst_vld",   out_valid3, 1'b0);
        chk("t5_rst_alu_a", alu_a3,     64'd0);
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid3 || alu_start3) bad = 1'b1;
        end
        chk("t5_quiet_after_rst", bad, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
